// File: rtl/programmable_delay.sv
// Programmable-depth sample delay line with clock enable, clamped delay
// selection, and a settle counter that holds 'locked' low after a delay change.
module programmable_delay #(
  parameter int unsigned N             = 8,
  parameter int unsigned MAX_DELAY     = 16,
  parameter int unsigned DEFAULT_DELAY = 1,
  localparam int unsigned DW           = $clog2(MAX_DELAY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic [DW-1:0] delay,
  input  logic [N-1:0]  idata,
  input  logic          ivalid,
  output logic [N-1:0]  odata,
  output logic          ovalid,
  output logic          locked
);

  // Element k holds stage s[k+1]; bit k of v holds its valid flag.
  logic [N-1:0]         s_q [MAX_DELAY];
  logic [N-1:0]         s_d [MAX_DELAY];
  logic [MAX_DELAY-1:0] v_q;
  logic [MAX_DELAY-1:0] v_d;

  logic [DW-1:0] dreg_q;
  logic [DW-1:0] dreg_d;
  logic [DW-1:0] cnt_q;
  logic [DW-1:0] cnt_d;

  logic [DW-1:0] delay_clamped;
  logic          dreg_change;
  logic [N-1:0]  tap_data;
  logic          tap_valid;

  // Clamp the requested delay to the deepest available stage.
  always_comb begin
    delay_clamped = delay;
    if (delay > DW'(MAX_DELAY)) begin
      delay_clamped = DW'(MAX_DELAY);
    end
  end

  assign dreg_change = (delay_clamped != dreg_q);

  // Shift the pipeline one stage on each enabled edge, otherwise hold.
  always_comb begin
    s_d = s_q;
    v_d = v_q;
    if (ce) begin
      s_d[0] = idata;
      v_d[0] = ivalid;
      for (int k = 1; k < int'(MAX_DELAY); k++) begin
        s_d[k] = s_q[k-1];
        v_d[k] = v_q[k-1];
      end
    end
  end

  // Active delay tracks the clamped request; a change restarts the settle
  // count, which otherwise counts enabled edges down to zero.
  always_comb begin
    dreg_d = dreg_q;
    cnt_d  = cnt_q;
    if (dreg_change) begin
      dreg_d = delay_clamped;
      cnt_d  = delay_clamped;
    end else if (ce && (cnt_q != '0)) begin
      cnt_d = cnt_q - DW'(1);
    end
  end

  // Pipeline storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(MAX_DELAY); k++) begin
        s_q[k] <= '0;
      end
      v_q <= '0;
    end else begin
      s_q <= s_d;
      v_q <= v_d;
    end
  end

  // Delay selection and settle counter; reset abandons any settle in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dreg_q <= DW'(DEFAULT_DELAY);
      cnt_q  <= '0;
    end else begin
      dreg_q <= dreg_d;
      cnt_q  <= cnt_d;
    end
  end

  // Output tap: zero delay is a combinational bypass of the pipeline.
  always_comb begin
    tap_data  = idata;
    tap_valid = ivalid;
    if (dreg_q != '0) begin
      tap_data  = '0;
      tap_valid = 1'b0;
      for (int k = 0; k < int'(MAX_DELAY); k++) begin
        if (dreg_q == DW'(k + 1)) begin
          tap_data  = s_q[k];
          tap_valid = v_q[k];
        end
      end
    end
  end

  assign locked = (cnt_q == '0);
  assign odata  = tap_data;
  assign ovalid = tap_valid & locked;

endmodule

// File: tb/tb_programmable_delay.sv
// Self-checking bench for programmable_delay: a scoreboard of expected samples
// keyed by the enabled edge on which each should reach the output tap.
module tb_programmable_delay;

  localparam int unsigned N    = 8;
  localparam int unsigned MAXD = 16;
  localparam int unsigned DW   = $clog2(MAXD + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce;
  logic [DW-1:0] delay;
  logic [N-1:0]  idata;
  logic          ivalid;
  logic [N-1:0]  odata;
  logic          ovalid;
  logic          locked;
  logic [N-1:0]  odata0;
  logic          ovalid0;
  logic          locked0;

  always #5 clk = ~clk;

  programmable_delay #(.N(N), .MAX_DELAY(MAXD), .DEFAULT_DELAY(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .delay(delay), .idata(idata),
    .ivalid(ivalid), .odata(odata), .ovalid(ovalid), .locked(locked)
  );

  // Second instance to observe the zero-default-delay reset behaviour.
  programmable_delay #(.N(N), .MAX_DELAY(MAXD), .DEFAULT_DELAY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .delay(delay), .idata(idata),
    .ivalid(ivalid), .odata(odata0), .ovalid(ovalid0), .locked(locked0)
  );

  typedef struct {
    logic [N-1:0] data;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   ce_cnt  = 0;
  int   cur_dly = 1;
  int   errors  = 0;
  int   checks  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle; a captured valid sample is expected cur_dly-1 enabled
  // edges after the edge that captures it.
  task automatic drive(input logic c, input logic v, input logic [N-1:0] d);
    ce     = c;
    ivalid = v;
    idata  = d;
    if (c && v) sb.push_back('{d, ce_cnt + cur_dly});
    step();
    if (c) ce_cnt++;
  endtask

  // Expected tap content for the current enabled-edge count.
  task automatic sb_expect(output logic ev, output logic [N-1:0] ed);
    while (sb.size() > 0 && sb[0].due < ce_cnt) void'(sb.pop_front());
    ev = 1'b0;
    ed = '0;
    if (sb.size() > 0 && sb[0].due == ce_cnt) begin
      ev = 1'b1;
      ed = sb[0].data;
    end
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    ce     = 1'b0;
    ivalid = 1'b0;
    idata  = '0;
    delay  = DW'(1);
    step();
    step();
    rst_n  = 1'b1;
    sb.delete();
    cur_dly = 1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ce     = 1'b1;
    ivalid = 1'b1;
    idata  = 8'hA5;
    delay  = DW'(1);
    step();
    step();
    checks++; if (odata !== 8'h00) begin errors++; $display("FAIL reset_odata: got %h want 00", odata); end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid: got %b want 0", ovalid); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL reset_locked: got %b want 1", locked); end
    checks++; if (odata0 !== 8'hA5) begin errors++; $display("FAIL reset_d0_odata: got %h want a5", odata0); end
    checks++; if (ovalid0 !== 1'b1) begin errors++; $display("FAIL reset_d0_ovalid: got %b want 1", ovalid0); end
    ivalid = 1'b0;
    idata  = 8'h3C;
    #1;
    checks++; if (ovalid0 !== 1'b0 || odata0 !== 8'h3C) begin errors++; $display("FAIL reset_d0_follow: got %b/%h want 0/3c", ovalid0, odata0); end
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'h00);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL release_locked: got %b want 1", locked); end
  endtask

  task automatic test_steady();
    logic ev;
    logic [N-1:0] ed;
    int first_rise = -1;
    int nout = 0;
    apply_reset();
    delay = DW'(5);
    cur_dly = 5;
    drive(1'b1, 1'b0, 8'h00);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL steady_settle_start: got %b want 0", locked); end
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL steady_settle_mid: got %b want 0", locked); end
    drive(1'b1, 1'b0, 8'h00);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL steady_settle_end: got %b want 1", locked); end
    for (int i = 1; i <= 38; i++) begin
      drive(1'b1, i <= 32, N'(i));
      sb_expect(ev, ed);
      checks++; if (ovalid !== ev) begin errors++; $display("FAIL steady_ovalid[%0d]: got %b want %b", i, ovalid, ev); end
      if (ev) begin
        checks++; if (odata !== ed) begin errors++; $display("FAIL steady_odata[%0d]: got %h want %h", i, odata, ed); end
      end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL steady_locked[%0d]: got %b want 1", i, locked); end
      if (ovalid === 1'b1) begin
        nout++;
        if (first_rise < 0) first_rise = i;
      end
    end
    checks++; if (first_rise != 5) begin errors++; $display("FAIL steady_first_rise: got %0d want 5", first_rise); end
    checks++; if (nout != 32) begin errors++; $display("FAIL steady_count: got %0d want 32", nout); end
  endtask

  task automatic test_ce_gaps();
    logic ev;
    logic [N-1:0] ed;
    logic [N-1:0] prev_d;
    logic prev_v;
    int nout = 0;
    apply_reset();
    delay = DW'(3);
    cur_dly = 3;
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gaps_locked: got %b want 1", locked); end
    for (int i = 0; i < 40; i++) begin
      prev_d = odata;
      prev_v = ovalid;
      drive((i % 2) == 0, i < 32, N'(8'h40 + i));
      sb_expect(ev, ed);
      checks++; if (ovalid !== ev) begin errors++; $display("FAIL gaps_ovalid[%0d]: got %b want %b", i, ovalid, ev); end
      if (ev) begin
        checks++; if (odata !== ed) begin errors++; $display("FAIL gaps_odata[%0d]: got %h want %h", i, odata, ed); end
      end
      if ((i % 2) != 0) begin
        checks++; if (odata !== prev_d || ovalid !== prev_v) begin errors++; $display("FAIL gaps_hold[%0d]: got %b/%h want %b/%h", i, ovalid, odata, prev_v, prev_d); end
      end else if (ovalid === 1'b1) begin
        nout++;
      end
    end
    checks++; if (nout != 16) begin errors++; $display("FAIL gaps_count: got %0d want 16", nout); end
  endtask

  task automatic test_delay_change();
    logic ev;
    logic [N-1:0] ed;
    int nout = 0;
    apply_reset();
    delay = DW'(4);
    cur_dly = 4;
    repeat (5) drive(1'b1, 1'b0, 8'h00);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL chg_locked4: got %b want 1", locked); end
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, i < 10, N'(8'h20 + i));
      sb_expect(ev, ed);
      checks++; if (ovalid !== ev || (ev && odata !== ed)) begin errors++; $display("FAIL chg_d4[%0d]: got %b/%h want %b/%h", i, ovalid, odata, ev, ed); end
    end
    delay = DW'(10);
    cur_dly = 10;
    sb.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, N'(8'h80 + i));
      sb_expect(ev, ed);
      checks++; if (locked !== 1'b0 || ovalid !== 1'b0) begin errors++; $display("FAIL chg_settle[%0d]: got locked=%b ovalid=%b want 0/0", i, locked, ovalid); end
    end
    for (int i = 10; i < 30; i++) begin
      drive(1'b1, i < 20, N'(8'h80 + i));
      sb_expect(ev, ed);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL chg_locked10[%0d]: got %b want 1", i, locked); end
      checks++; if (ovalid !== ev || (ev && odata !== ed)) begin errors++; $display("FAIL chg_d10[%0d]: got %b/%h want %b/%h", i, ovalid, odata, ev, ed); end
      if (ovalid === 1'b1) nout++;
    end
    checks++; if (nout != 19) begin errors++; $display("FAIL chg_count: got %0d want 19", nout); end
  endtask

  task automatic test_rechange_clamp();
    logic ev;
    logic [N-1:0] ed;
    int ce_after = 0;
    int guard = 0;
    delay = DW'(8);
    cur_dly = 8;
    drive(1'b1, 1'b1, 8'hB0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL clamp_settle8: got %b want 0", locked); end
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b1, N'(8'hB0 + i));
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL clamp_settle8[%0d]: got %b want 0", i, locked); end
    end
    delay = DW'(20);
    cur_dly = 16;
    sb.delete();
    drive(1'b1, 1'b1, 8'hC0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL clamp_reload: got %b want 0", locked); end
    while (ce_after < 16 && guard < 40) begin
      guard++;
      drive((guard % 4) != 3, 1'b1, N'(8'hC0 + guard));
      if ((guard % 4) != 3) ce_after++;
      sb_expect(ev, ed);
      checks++; if (locked !== (ce_after >= 16) || (ce_after < 16 && ovalid !== 1'b0)) begin errors++; $display("FAIL clamp_settle16[%0d]: got locked=%b ovalid=%b want locked=%b", ce_after, locked, ovalid, ce_after >= 16); end
    end
    checks++; if (ce_after != 16) begin errors++; $display("FAIL clamp_budget: got %0d want 16 ce-edges", ce_after); end
    for (int i = 0; i < 28; i++) begin
      drive(1'b1, i < 10, N'(8'hE0 + i));
      sb_expect(ev, ed);
      checks++; if (locked !== 1'b1 || ovalid !== ev || (ev && odata !== ed)) begin errors++; $display("FAIL clamp_d16[%0d]: got %b/%b/%h want 1/%b/%h", i, locked, ovalid, odata, ev, ed); end
    end
  endtask

  task automatic test_zero_delay();
    logic [N-1:0] pat_d [5] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h3C};
    logic         pat_v [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    delay = DW'(0);
    cur_dly = 0;
    drive(1'b1, 1'b0, 8'h00);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL zero_locked: got %b want 1", locked); end
    for (int i = 0; i < 5; i++) begin
      ce     = (i % 2) == 0;
      idata  = pat_d[i];
      ivalid = pat_v[i];
      #2;
      checks++; if (odata !== pat_d[i] || ovalid !== pat_v[i]) begin errors++; $display("FAIL zero_bypass[%0d]: got %b/%h want %b/%h", i, ovalid, odata, pat_v[i], pat_d[i]); end
      step();
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    delay = DW'(6);
    cur_dly = 6;
    drive(1'b1, 1'b1, 8'h11);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL areset_settling: got %b want 0", locked); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (odata !== 8'h00) begin errors++; $display("FAIL areset_odata: got %h want 00", odata); end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL areset_ovalid: got %b want 0", ovalid); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL areset_locked: got %b want 1", locked); end
    step();
    rst_n = 1'b1;
    delay = DW'(1);
    drive(1'b1, 1'b1, 8'h77);
    checks++; if (locked !== 1'b1 || ovalid !== 1'b1 || odata !== 8'h77) begin errors++; $display("FAIL areset_default: got %b/%b/%h want 1/1/77", locked, ovalid, odata); end
    delay = DW'(3);
    drive(1'b1, 1'b0, 8'h00);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL areset_new_settle: got %b want 0", locked); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    ce     = 1'b0;
    ivalid = 1'b0;
    idata  = '0;
    delay  = DW'(1);
    test_reset();
    test_steady();
    test_ce_gaps();
    test_delay_change();
    test_rechange_clamp();
    test_zero_delay();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
